counter_sweep_ctrl: RTL
=======================

COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the width of the counter and peak value.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: request a sweep run; sampled only in IDLE.
REQ-005 Port peak, input, WIDTH bits: sweep peak value; latched when start is accepted.
REQ-006 Port reps, input, 4 bits: number of up/down sweeps; latched when start is accepted.
REQ-007 Port pause, input, 1 bit: freezes count and state while high.
REQ-008 Port abort, input, 1 bit: synchronous abort of the run in progress.
REQ-009 Port count, output, WIDTH bits: current counter value.
REQ-010 Port dir_up, output, 1 bit: high while the FSM is in UP.
REQ-011 Port busy, output, 1 bit: high in UP or DOWN.
REQ-012 Port done, output, 1 bit: high for exactly one cycle when the run completes.
REQ-013 Port err, output, 1 bit: high for exactly one cycle when start is rejected.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, UP, DOWN and DONE.
REQ-015 In IDLE with start=1 and abort=0, the block SHALL latch peak into peak_l and reps into reps_left.
REQ-016 If the latched peak is 0 or reps is 0, the block SHALL stay in IDLE and assert err for one cycle.
REQ-017 Otherwise the next state SHALL be UP with count=0.
REQ-018 In UP with pause=0, count SHALL increment by 1 each cycle.
REQ-019 In UP, the edge on which count becomes peak_l SHALL also move the state to DOWN.
REQ-020 In DOWN with pause=0, count SHALL decrement by 1 each cycle.
REQ-021 In DOWN, the edge on which count becomes 0 SHALL decrement reps_left.
REQ-022 On that same edge, the next state SHALL be DONE if reps_left was 1, else UP.
REQ-023 Count SHALL never exceed peak_l and SHALL never wrap.
REQ-024 peak = 2^WIDTH-1 SHALL be legal and SHALL sweep without overflow.
REQ-025 Count sequence from acceptance SHALL be 0,1,...,peak,...,1,0, repeated reps times.
REQ-026 The 0 between consecutive sweeps SHALL appear only once.
REQ-027 Accept-to-DONE latency SHALL be 2*peak*reps+1 edges.
REQ-028 DONE SHALL last one cycle with done=1 and count=0, then the FSM SHALL return to IDLE.
REQ-029 While pause=1, count, state and reps_left SHALL hold.
REQ-030 Outputs derived from state (dir_up, busy, done) SHALL remain valid while pause=1.
REQ-031 abort=1 in UP or DOWN SHALL force IDLE and count=0 at the next edge, with no done pulse.
REQ-032 abort SHALL override pause.
REQ-033 abort=1 in IDLE SHALL block acceptance of start that cycle.
REQ-034 start while busy or in DONE SHALL be ignored.
REQ-035 Changes on peak or reps after acceptance SHALL have no effect on the run in progress.
REQ-036 done and err SHALL never be asserted in the same cycle.

Reset
REQ-037 rst=0 SHALL immediately, independent of clk, force state=IDLE and count=0.
REQ-038 rst=0 SHALL immediately force peak_l=0, reps_left=0, and dir_up, busy, done, err all 0.
REQ-039 Reset asserted mid-run SHALL discard the run without a done pulse.
REQ-040 After rst returns to 1, the first start SHALL be accepted on the next rising edge.

Verification
REQ-041 The bench SHALL cover: peak=3, reps=1, start pulse -> count 0,1,2,3,2,1,0, done pulse 7 edges after accept, dir_up high for the 0..2 steps.
REQ-042 The bench SHALL cover: peak=2, reps=2 -> count 0,1,2,1,0,1,2,1,0, then done; reps_left observed 2 then 1.
REQ-043 The bench SHALL cover: peak=0 or reps=0 with start -> err one cycle, busy stays 0, count 0.
REQ-044 The bench SHALL cover: pause held 3 cycles at count=2 in UP -> count holds at 2, then resumes at 3; done is 3 cycles late.
REQ-045 The bench SHALL cover: abort at count=5 in DOWN (peak=8) -> next edge IDLE, count=0, no done; a following start runs normally.
REQ-046 The bench SHALL cover: rst=0 pulsed between edges mid-run -> outputs zero immediately; peak=255 run completes with max count 255 and no wrap.

Source files
------------

// File: rtl/counter_sweep_ctrl.sv
// rtl/counter_sweep_ctrl.sv - up/down sweep counter: 0..peak..0, repeated reps times
// Runs one sweep set per accepted start; a start is refused (err) when peak or reps is zero.
module counter_sweep_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] peak,
  input  logic [3:0]       reps,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             dir_up,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] peak_l_q, peak_l_d;
  logic [3:0]       reps_left_q, reps_left_d;
  logic             err_q, err_d;

  logic accept;
  logic bad_args;
  logic at_top;
  logic at_bottom;

  assign accept    = (state_q == S_IDLE) && start && !abort;
  assign bad_args  = (peak == CNT_ZERO) || (reps == 4'd0);
  // Turnaround is decided on the edge that produces the extreme value, so
  // count only ever reaches peak_l and never steps past it or below zero.
  assign at_top    = (count_q == (peak_l_q - CNT_ONE));
  assign at_bottom = (count_q == CNT_ONE);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    peak_l_d    = peak_l_q;
    reps_left_d = reps_left_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        count_d = CNT_ZERO;
        if (accept) begin
          peak_l_d    = peak;
          reps_left_d = reps;
          if (bad_args) begin
            err_d = 1'b1;
          end else begin
            state_d = S_UP;
          end
        end
      end

      S_UP: begin
        if (abort) begin
          state_d     = S_IDLE;
          count_d     = CNT_ZERO;
          reps_left_d = 4'd0;
        end else if (!pause) begin
          count_d = count_q + CNT_ONE;
          if (at_top) begin
            state_d = S_DOWN;
          end
        end
      end

      S_DOWN: begin
        if (abort) begin
          state_d     = S_IDLE;
          count_d     = CNT_ZERO;
          reps_left_d = 4'd0;
        end else if (!pause) begin
          count_d = count_q - CNT_ONE;
          // Reaching zero closes a sweep; the same zero opens the next one.
          if (at_bottom) begin
            reps_left_d = reps_left_q - 4'd1;
            state_d     = (reps_left_q == 4'd1) ? S_DONE : S_UP;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        count_d = CNT_ZERO;
      end

      default: begin
        state_d = S_IDLE;
        count_d = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      count_q     <= CNT_ZERO;
      peak_l_q    <= CNT_ZERO;
      reps_left_q <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      peak_l_q    <= peak_l_d;
      reps_left_q <= reps_left_d;
      err_q       <= err_d;
    end
  end

  assign count  = count_q;
  assign dir_up = (state_q == S_UP);
  assign busy   = (state_q == S_UP) || (state_q == S_DOWN);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;

endmodule
